// File: rtl/sprite_motion_engine.sv
// sprite_motion_engine
//   Time-multiplexed position engine for Pac-Man (sprite 0) and the four
//   ghosts. Each tick starts one sweep over all sprites. A sprite between tile
//   centres keeps moving in its current direction. A sprite on a tile centre
//   asks the shared valid-move detector which directions are open, then takes
//   its buffered turn, or keeps its current direction, or stops.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   tick            one-cycle pulse that starts a sweep
//   dir_in          per-sprite requested direction, one-hot {L,D,U,R}
//   vm_req/vm_x/vm_y  valid-move query (request held until vm_ack)
//   vm_ack/vm_moves   query answer and the allowed directions
//   pos_x/pos_y     packed per-sprite position, sprite 0 in LSBs
//   cur_dir         packed per-sprite motion direction, 0 = stopped
//   busy            sweep in progress
//   done            one-cycle pulse at the end of a sweep
//   tick_overrun    one-cycle pulse after a tick that arrived while not idle
module sprite_motion_engine #(
  parameter int unsigned NUM_SPRITES  = 5,
  parameter int unsigned X_W          = 11,
  parameter int unsigned Y_W          = 10,
  parameter int unsigned STEP         = 16,
  parameter int unsigned PIX_PER_TICK = 2,
  parameter int unsigned X_MIN        = 343,
  parameter int unsigned X_MAX        = 1607,
  parameter int unsigned Y_MIN        = 34,
  parameter int unsigned Y_MAX        = 818,
  parameter logic [NUM_SPRITES*X_W-1:0] RESET_X =
    {11'd615, 11'd503, 11'd615, 11'd663, 11'd967},
  parameter logic [NUM_SPRITES*Y_W-1:0] RESET_Y =
    {10'd370, 10'd66, 10'd258, 10'd434, 10'd66}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tick,
  input  logic [4*NUM_SPRITES-1:0]   dir_in,
  output logic                       vm_req,
  output logic [X_W-1:0]             vm_x,
  output logic [Y_W-1:0]             vm_y,
  input  logic                       vm_ack,
  input  logic [3:0]                 vm_moves,
  output logic [X_W*NUM_SPRITES-1:0] pos_x,
  output logic [Y_W*NUM_SPRITES-1:0] pos_y,
  output logic [4*NUM_SPRITES-1:0]   cur_dir,
  output logic                       busy,
  output logic                       done,
  output logic                       tick_overrun
);

  localparam int unsigned SUB_N = STEP / PIX_PER_TICK;
  localparam int unsigned SUB_W = (SUB_N > 1) ? $clog2(SUB_N) : 1;
  localparam int unsigned IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_N - 1);

  localparam logic [X_W:0] X_MIN_E = (X_W+1)'(X_MIN);
  localparam logic [X_W:0] X_MAX_E = (X_W+1)'(X_MAX);
  localparam logic [X_W:0] X_PIX   = (X_W+1)'(PIX_PER_TICK);
  localparam logic [Y_W:0] Y_MIN_E = (Y_W+1)'(Y_MIN);
  localparam logic [Y_W:0] Y_MAX_E = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W:0] Y_PIX   = (Y_W+1)'(PIX_PER_TICK);

  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_QUERY,
    S_APPLY,
    S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic [X_W-1:0]   px   [NUM_SPRITES];
  logic [Y_W-1:0]   py   [NUM_SPRITES];
  logic [3:0]       cdir [NUM_SPRITES];
  logic [3:0]       pdir [NUM_SPRITES];
  logic [SUB_W-1:0] sub  [NUM_SPRITES];

  logic [IDX_W-1:0] idx;
  logic [3:0]       move_dir;
  logic             tick_overrun_q;

  // View of the sprite currently addressed by the sweep
  logic [X_W-1:0]   sel_x;
  logic [Y_W-1:0]   sel_y;
  logic [3:0]       sel_cur;
  logic [3:0]       sel_pend;
  logic [SUB_W-1:0] sel_sub;
  logic             sel_moving;
  logic [3:0]       ack_dir;

  logic [X_W:0]     x_ext;
  logic [Y_W:0]     y_ext;
  logic             wrapped;
  logic [X_W-1:0]   new_x;
  logic [Y_W-1:0]   new_y;
  logic [SUB_W-1:0] new_sub;

  always_comb begin
    sel_x      = px[idx];
    sel_y      = py[idx];
    sel_cur    = cdir[idx];
    sel_pend   = pdir[idx];
    sel_sub    = sub[idx];
    sel_moving = (sel_sub != '0) && (sel_cur != '0);
  end

  // Direction chosen on the ack cycle: buffered turn first, then keep going
  always_comb begin
    ack_dir = '0;
    if ((sel_pend & vm_moves) != '0) begin
      ack_dir = sel_pend;
    end else if ((sel_cur & vm_moves) != '0) begin
      ack_dir = sel_cur;
    end
  end

  // One step of motion with wrap-around; one extra bit keeps the
  // bound comparisons free of modular truncation
  always_comb begin
    x_ext   = {1'b0, sel_x};
    y_ext   = {1'b0, sel_y};
    wrapped = 1'b0;
    case (move_dir)
      DIR_RIGHT: begin
        x_ext = x_ext + X_PIX;
        if (x_ext > X_MAX_E) begin
          x_ext   = X_MIN_E;
          wrapped = 1'b1;
        end
      end
      DIR_LEFT: begin
        x_ext = x_ext - X_PIX;
        if (x_ext < X_MIN_E) begin
          x_ext   = X_MAX_E;
          wrapped = 1'b1;
        end
      end
      DIR_DOWN: begin
        y_ext = y_ext + Y_PIX;
        if (y_ext > Y_MAX_E) begin
          y_ext   = Y_MIN_E;
          wrapped = 1'b1;
        end
      end
      DIR_UP: begin
        y_ext = y_ext - Y_PIX;
        if (y_ext < Y_MIN_E) begin
          y_ext   = Y_MAX_E;
          wrapped = 1'b1;
        end
      end
      default: ;
    endcase
    new_x   = x_ext[X_W-1:0];
    new_y   = y_ext[Y_W-1:0];
    new_sub = (wrapped || (sel_sub == SUB_LAST)) ? '0 : sel_sub + SUB_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (tick) state_nxt = S_SELECT;
      S_SELECT: state_nxt = sel_moving ? S_APPLY : S_QUERY;
      S_QUERY:  if (vm_ack) state_nxt = S_APPLY;
      S_APPLY:  state_nxt = (idx == LAST_IDX) ? S_FINISH : S_SELECT;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        px[i]   <= RESET_X[i*X_W +: X_W];
        py[i]   <= RESET_Y[i*Y_W +: Y_W];
        cdir[i] <= '0;
        pdir[i] <= '0;
        sub[i]  <= '0;
      end
      idx            <= '0;
      move_dir       <= '0;
      tick_overrun_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        if ($onehot(dir_in[4*i +: 4])) begin
          pdir[i] <= dir_in[4*i +: 4];
        end
      end

      tick_overrun_q <= tick && (state != S_IDLE);

      case (state)
        S_IDLE: begin
          if (tick) idx <= '0;
        end
        S_SELECT: begin
          if (sel_moving) move_dir <= sel_cur;
        end
        S_QUERY: begin
          if (vm_ack) move_dir <= ack_dir;
        end
        S_APPLY: begin
          cdir[idx] <= move_dir;
          if (move_dir != '0) begin
            px[idx]  <= new_x;
            py[idx]  <= new_y;
            sub[idx] <= new_sub;
          end
          if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pos_x   = '0;
    pos_y   = '0;
    cur_dir = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      pos_x[i*X_W +: X_W] = px[i];
      pos_y[i*Y_W +: Y_W] = py[i];
      cur_dir[4*i +: 4]   = cdir[i];
    end
  end

  assign vm_req       = (state == S_QUERY);
  assign vm_x         = sel_x;
  assign vm_y         = sel_y;
  assign busy         = (state == S_SELECT) || (state == S_QUERY) || (state == S_APPLY);
  assign done         = (state == S_FINISH);
  assign tick_overrun = tick_overrun_q;

endmodule

// File: tb/tb_sprite_motion_engine.sv
// tb_sprite_motion_engine
//   Self-checking bench for sprite_motion_engine. The bench plays the part of
//   the valid-move detector, answering each query with a per-sprite set of
//   allowed moves after a random delay, and keeps a sprite-level model of
//   position, direction, buffered turn and tile phase.
module tb_sprite_motion_engine;

  localparam int N  = 5;
  localparam int XW = 11;
  localparam int YW = 10;

  logic              clk;
  logic              rst_n;
  logic              tick;
  logic [4*N-1:0]    dir_in;
  logic              vm_req;
  logic [XW-1:0]     vm_x;
  logic [YW-1:0]     vm_y;
  logic              vm_ack;
  logic [3:0]        vm_moves;
  logic [XW*N-1:0]   pos_x;
  logic [YW*N-1:0]   pos_y;
  logic [4*N-1:0]    cur_dir;
  logic              busy;
  logic              done;
  logic              tick_overrun;

  sprite_motion_engine #(
    .NUM_SPRITES (N),
    .X_W         (XW),
    .Y_W         (YW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .dir_in       (dir_in),
    .vm_req       (vm_req),
    .vm_x         (vm_x),
    .vm_y         (vm_y),
    .vm_ack       (vm_ack),
    .vm_moves     (vm_moves),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .cur_dir      (cur_dir),
    .busy         (busy),
    .done         (done),
    .tick_overrun (tick_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sprite-level model
  int         rst_x [N] = '{967, 663, 615, 503, 615};
  int         rst_y [N] = '{66, 434, 258, 66, 370};
  int         mx    [N];
  int         my    [N];
  int         msub  [N];
  logic [3:0] mcur  [N];
  logic [3:0] mpend [N];
  logic [3:0] mmoves[N];

  task automatic model_reset();
    for (int s = 0; s < N; s++) begin
      mx[s] = rst_x[s]; my[s] = rst_y[s];
      msub[s] = 0; mcur[s] = 4'b0000; mpend[s] = 4'b0000;
    end
  endtask

  task automatic set_dir(input int s, input logic [3:0] d);
    dir_in[4*s +: 4] = d;
    if ($countones(d) == 1) mpend[s] = d;
  endtask

  task automatic set_all_moves(input logic [3:0] m);
    for (int s = 0; s < N; s++) mmoves[s] = m;
  endtask

  task automatic model_step(input int s);
    logic [3:0] md;
    bit wrapped;
    if (msub[s] != 0 && mcur[s] != 4'b0000)  md = mcur[s];
    else if ((mpend[s] & mmoves[s]) != 4'b0) md = mpend[s];
    else if ((mcur[s] & mmoves[s]) != 4'b0)  md = mcur[s];
    else                                     md = 4'b0000;
    mcur[s] = md;
    if (md != 4'b0000) begin
      wrapped = 0;
      case (md)
        4'b0001: begin mx[s] += 2; if (mx[s] > 1607) begin mx[s] = 343;  wrapped = 1; end end
        4'b1000: begin mx[s] -= 2; if (mx[s] < 343)  begin mx[s] = 1607; wrapped = 1; end end
        4'b0100: begin my[s] += 2; if (my[s] > 818)  begin my[s] = 34;   wrapped = 1; end end
        default: begin my[s] -= 2; if (my[s] < 34)   begin my[s] = 818;  wrapped = 1; end end
      endcase
      msub[s] = wrapped ? 0 : (msub[s] + 1) % 8;
    end
  endtask

  task automatic compare_all(input string tag);
    for (int s = 0; s < N; s++) begin
      check($sformatf("%s_x%0d", tag, s), pos_x[s*XW +: XW], mx[s]);
      check($sformatf("%s_y%0d", tag, s), pos_y[s*YW +: YW], my[s]);
      check($sformatf("%s_dir%0d", tag, s), cur_dir[4*s +: 4], mcur[s]);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_x0"}, pos_x[0 +: XW], 967);
    check({tag, "_y0"}, pos_y[0 +: YW], 66);
    check({tag, "_x4"}, pos_x[4*XW +: XW], 615);
    check({tag, "_y4"}, pos_y[4*YW +: YW], 370);
    check({tag, "_dirs"}, cur_dir, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_req"}, vm_req, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ovr"}, tick_overrun, 0);
  endtask

  // One full sweep: tick, answer every query, wait for done, update model.
  // stall: hold the first ack 20 cycles and send a tick in the middle.
  // tick_end: send a tick in the done cycle.
  task automatic do_sweep(input bit stall, input bit tick_end, output int nq);
    int qs[$];
    int expq, cyc, s, lat, ov;
    bit got_done;
    for (int i = 0; i < N; i++)
      if (!(msub[i] != 0 && mcur[i] != 4'b0000)) qs.push_back(i);
    expq = qs.size();
    nq = 0; cyc = 0; got_done = 0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    check("busy_start", busy, 1);
    while (!got_done && cyc < 400) begin
      if (vm_req) begin
        nq++;
        s = 0;
        if (qs.size() > 0) begin
          s = qs.pop_front();
          check("query_x", vm_x, mx[s]);
          check("query_y", vm_y, my[s]);
        end
        if (stall && nq == 1) begin
          ov = 0;
          for (int i = 0; i < 20; i++) begin
            if (i == 4) tick = 1'b1;
            @(negedge clk); cyc++;
            if (i == 4) begin
              tick = 1'b0;
              check("overrun_pulse", tick_overrun, 1);
            end else begin
              ov += int'(tick_overrun);
            end
            check("req_held_stall", vm_req, 1);
          end
          check("overrun_once", ov, 0);
        end else begin
          lat = $urandom_range(0, 3);
          for (int i = 0; i < lat; i++) begin
            @(negedge clk); cyc++;
            check("req_held", vm_req, 1);
            check("query_x_stable", vm_x, mx[s]);
          end
        end
        vm_moves = mmoves[s];
        vm_ack   = 1'b1;
        @(negedge clk); cyc++;
        vm_ack   = 1'b0;
        vm_moves = 4'($urandom);
        check("req_drop", vm_req, 0);
      end else if (done) begin
        got_done = 1;
        check("busy_at_done", busy, 0);
        if (tick_end) begin
          tick = 1'b1;
          @(negedge clk); tick = 1'b0;
          check("finish_overrun", tick_overrun, 1);
          check("finish_tick_ignored", busy, 0);
          @(negedge clk);
          check("finish_still_idle", busy, 0);
        end else begin
          @(negedge clk);
          check("done_pulse", done, 0);
        end
      end else begin
        @(negedge clk); cyc++;
      end
    end
    check("sweep_done", got_done, 1);
    check("query_count", nq, expq);
    for (int i = 0; i < N; i++) model_step(i);
    compare_all("sweep");
  endtask

  typedef struct {
    logic [3:0] dir0;
    logic [3:0] moves;
    int         ex;
    int         ey;
    logic [3:0] ecur;
    int         eq;
  } vec_t;

  vec_t tbl [20];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nq, w;
    logic [3:0] d;

    tbl[0]  = '{4'b0001, 4'b1111, 969, 66, 4'b0001, 5};
    tbl[1]  = '{4'b0001, 4'b1111, 971, 66, 4'b0001, 4};
    tbl[2]  = '{4'b0001, 4'b1111, 973, 66, 4'b0001, 4};
    tbl[3]  = '{4'b0001, 4'b1111, 975, 66, 4'b0001, 4};
    tbl[4]  = '{4'b0001, 4'b1111, 977, 66, 4'b0001, 4};
    tbl[5]  = '{4'b0001, 4'b1111, 979, 66, 4'b0001, 4};
    tbl[6]  = '{4'b0001, 4'b1111, 981, 66, 4'b0001, 4};
    tbl[7]  = '{4'b0001, 4'b1111, 983, 66, 4'b0001, 4};
    tbl[8]  = '{4'b1000, 4'b0000, 983, 66, 4'b0000, 5};
    tbl[9]  = '{4'b0001, 4'b1111, 985, 66, 4'b0001, 5};
    tbl[10] = '{4'b0001, 4'b1111, 987, 66, 4'b0001, 4};
    tbl[11] = '{4'b0001, 4'b1111, 989, 66, 4'b0001, 4};
    tbl[12] = '{4'b0010, 4'b0011, 991, 66, 4'b0001, 4};
    tbl[13] = '{4'b0010, 4'b0011, 993, 66, 4'b0001, 4};
    tbl[14] = '{4'b0010, 4'b0011, 995, 66, 4'b0001, 4};
    tbl[15] = '{4'b0010, 4'b0011, 997, 66, 4'b0001, 4};
    tbl[16] = '{4'b0010, 4'b0011, 999, 66, 4'b0001, 4};
    tbl[17] = '{4'b0010, 4'b0011, 999, 64, 4'b0010, 5};
    tbl[18] = '{4'b0010, 4'b0011, 999, 62, 4'b0010, 4};
    tbl[19] = '{4'b0100, 4'b1111, 999, 60, 4'b0010, 4};

    rst_n = 1'b1; tick = 1'b0; vm_ack = 1'b0; vm_moves = 4'b0000; dir_in = '0;
    #3 rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed run: straight, blocked, buffered turn, mid-tile reversal
    for (int k = 0; k < 20; k++) begin
      set_dir(0, tbl[k].dir0);
      set_all_moves(tbl[k].moves);
      do_sweep(0, 0, nq);
      check($sformatf("tbl%0d_x0", k), pos_x[0 +: XW], tbl[k].ex);
      check($sformatf("tbl%0d_y0", k), pos_y[0 +: YW], tbl[k].ey);
      check($sformatf("tbl%0d_dir0", k), cur_dir[3:0], tbl[k].ecur);
      check($sformatf("tbl%0d_nq", k), nq, tbl[k].eq);
    end

    // Wrap: UP through y=34, then RIGHT through x=1607
    dir_in = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    set_dir(0, 4'b0010);
    set_all_moves(4'b1111);
    for (int i = 0; i < 16; i++) do_sweep(0, 0, nq);
    check("wrap_y_edge", pos_y[0 +: YW], 34);
    do_sweep(0, 0, nq);
    check("wrap_y", pos_y[0 +: YW], 818);
    check("wrap_y_x", pos_x[0 +: XW], 967);
    set_dir(0, 4'b0001);
    for (int i = 0; i < 320; i++) do_sweep(0, 0, nq);
    check("wrap_x_edge", pos_x[0 +: XW], 1607);
    do_sweep(0, 0, nq);
    check("wrap_x", pos_x[0 +: XW], 343);
    check("wrap_x_y", pos_y[0 +: YW], 818);
    do_sweep(0, 0, nq);
    check("wrap_sub_zero_nq", nq, 5);
    check("wrap_after_x", pos_x[0 +: XW], 345);

    // Overrun during a stalled query, and a tick in the done cycle
    do_sweep(1, 0, nq);
    do_sweep(0, 1, nq);

    // Reset in the middle of a query, then a stray ack
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    w = 0;
    while (!vm_req && w < 20) begin @(negedge clk); w++; end
    check("req_before_rst", vm_req, 1);
    dir_in = '0;
    rst_n = 1'b0;
    #1;
    check("rst_req_async", vm_req, 0);
    check("rst_busy_async", busy, 0);
    model_reset();
    @(negedge clk);
    check_reset("midq_reset");
    set_dir(0, 4'b0001);
    vm_moves = 4'b1111;
    vm_ack = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("late_ack_req", vm_req, 0);
      check("late_ack_busy", busy, 0);
    end
    vm_ack = 1'b0;
    compare_all("late_ack");
    set_all_moves(4'b1111);
    do_sweep(0, 0, nq);
    check("resume_x0", pos_x[0 +: XW], 969);

    // Random directions, move sets and ack latencies
    for (int r = 0; r < 150; r++) begin
      for (int s = 0; s < N; s++) begin
        if ($urandom_range(0, 3) == 0) begin
          d = 4'($urandom);
          set_dir(s, d);
        end
        mmoves[s] = 4'($urandom_range(0, 15));
      end
      do_sweep(0, 0, nq);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
